// File: rtl/reg_file_banked_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
//   Shared defaults, derived widths, pair index helpers and the per-edge
//   operation encoding for the banked register file.
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_NUM_BANKS = 2;

    localparam int DEF_RSEL_W = $clog2(DEF_NUM_REGS);
    localparam int DEF_PSEL_W = DEF_RSEL_W - 1;
    localparam int DEF_BANK_W = (DEF_NUM_BANKS > 1) ? $clog2(DEF_NUM_BANKS) : 1;

    // One operation is executed per edge on the active bank.
    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_WR  = 2'd1,
        OP_INC = 2'd2,
        OP_DEC = 2'd3
    } op_e;

    // Low register of pair p.
    function automatic int pair_lo_idx(input int p);
        return p + p;
    endfunction

    // High register of pair p.
    function automatic int pair_hi_idx(input int p);
        return p + p + 32'sd1;
    endfunction

endpackage

// File: rtl/reg_file_banked_if.sv
// -----------------------------------------------------------------------------
// reg_file_banked_if
//   Access bus of the banked register file.
//   master: drives selects, write data and operation strobes; samples reads.
//   slave : the register file itself.
//   Signals: in_sel, out_b_sel, pair_sel, din, write_en, inc, dec, bank_swap
//            (master -> slave); out_a, out_b, out_c, pair_out, pair_wrap, bank
//            (slave -> master).
// -----------------------------------------------------------------------------
interface reg_file_banked_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_BANKS = DEF_NUM_BANKS
);
    localparam int RSEL_W = $clog2(NUM_REGS);
    localparam int PSEL_W = RSEL_W - 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [RSEL_W-1:0]   in_sel;
    logic [RSEL_W-1:0]   out_b_sel;
    logic [PSEL_W-1:0]   pair_sel;
    logic [DATA_W-1:0]   din;
    logic                write_en;
    logic                inc;
    logic                dec;
    logic                bank_swap;
    logic [DATA_W-1:0]   out_a;
    logic [DATA_W-1:0]   out_b;
    logic [DATA_W-1:0]   out_c;
    logic [2*DATA_W-1:0] pair_out;
    logic                pair_wrap;
    logic [BANK_W-1:0]   bank;

    modport master (
        output in_sel, out_b_sel, pair_sel, din, write_en, inc, dec, bank_swap,
        input  out_a, out_b, out_c, pair_out, pair_wrap, bank
    );

    modport slave (
        input  in_sel, out_b_sel, pair_sel, din, write_en, inc, dec, bank_swap,
        output out_a, out_b, out_c, pair_out, pair_wrap, bank
    );

endinterface

// File: rtl/reg_file_banked_pair_incdec.sv
// -----------------------------------------------------------------------------
// pair_incdec
//   Full-width +1 / -1 on a register pair, with wrap detection.
//   Ports: value (in), dec (in, 1 = decrement, 0 = increment),
//          result (out), wrap (out, inc of all-ones or dec of zero).
// -----------------------------------------------------------------------------
module pair_incdec #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic [W-1:0] result,
    output logic         wrap
);

    // Carry runs across the whole pair, so the high byte sees the low byte's carry.
    always_comb begin
        result = value;
        wrap   = 1'b0;
        if (dec) begin
            result = value - W'(1);
            wrap   = (value == {W{1'b0}});
        end else begin
            result = value + W'(1);
            wrap   = (value == {W{1'b1}});
        end
    end

endmodule

// File: rtl/reg_file_banked.sv
// -----------------------------------------------------------------------------
// reg_file_banked
//   Banked CPU register file with pair increment/decrement and shadow banks.
//   Ports: clk, rst (async, active-high), bus (reg_file_banked_if.slave):
//     in_sel/out_b_sel/pair_sel select, din/write_en write, inc/dec pair ops,
//     bank_swap advances the active bank; out_a/out_b/out_c/pair_out are
//     combinational reads of the active bank, pair_wrap and bank are registered.
// -----------------------------------------------------------------------------
module reg_file_banked
    import reg_file_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_BANKS = DEF_NUM_BANKS
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_banked_if.slave bus
);

    localparam int RSEL_W = $clog2(NUM_REGS);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PAIR_W = 2 * DATA_W;

    logic [DATA_W-1:0] regs_r [NUM_BANKS][NUM_REGS];
    logic [BANK_W-1:0] bank_r;
    logic              pair_wrap_r;

    op_e               op_s;
    logic [RSEL_W-1:0] lo_idx_s;
    logic [RSEL_W-1:0] hi_idx_s;
    logic [RSEL_W-1:0] out_c_idx_s;
    logic [PAIR_W-1:0] pair_val_s;
    logic [PAIR_W-1:0] incdec_res_s;
    logic              incdec_wrap_s;
    logic              is_dec_s;

    // Decode the strobes into the single operation executed this edge.
    always_comb begin
        op_s = OP_NOP;
        if (bus.write_en) begin
            op_s = OP_WR;
        end else if (bus.inc && !bus.dec) begin
            op_s = OP_INC;
        end else if (bus.dec && !bus.inc) begin
            op_s = OP_DEC;
        end else begin
            op_s = OP_NOP;
        end
    end

    assign lo_idx_s    = RSEL_W'(pair_lo_idx(int'(bus.pair_sel)));
    assign hi_idx_s    = RSEL_W'(pair_hi_idx(int'(bus.pair_sel)));
    assign out_c_idx_s = bus.out_b_sel + RSEL_W'(1);
    assign pair_val_s  = {regs_r[bank_r][hi_idx_s], regs_r[bank_r][lo_idx_s]};
    assign is_dec_s    = (op_s == OP_DEC);

    pair_incdec #(
        .W (PAIR_W)
    ) u_pair_incdec (
        .value  (pair_val_s),
        .dec    (is_dec_s),
        .result (incdec_res_s),
        .wrap   (incdec_wrap_s)
    );

    // Register storage; all updates land in the bank active before any swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs_r[b][r] <= '0;
                end
            end
        end else begin
            case (op_s)
                OP_WR: begin
                    regs_r[bank_r][bus.in_sel] <= bus.din;
                end
                OP_INC, OP_DEC: begin
                    regs_r[bank_r][hi_idx_s] <= incdec_res_s[PAIR_W-1:DATA_W];
                    regs_r[bank_r][lo_idx_s] <= incdec_res_s[DATA_W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    // Active bank counter; a single-bank build never leaves bank 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_r <= '0;
        end else if (bus.bank_swap && (NUM_BANKS > 1)) begin
            bank_r <= bank_r + BANK_W'(1);
        end else begin
            bank_r <= bank_r;
        end
    end

    // Wrap flag is rewritten every edge so it stays high for one cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_wrap_r <= 1'b0;
        end else begin
            pair_wrap_r <= ((op_s == OP_INC) || (op_s == OP_DEC)) && incdec_wrap_s;
        end
    end

    assign bus.out_a     = regs_r[bank_r][bus.in_sel];
    assign bus.out_b     = regs_r[bank_r][bus.out_b_sel];
    assign bus.out_c     = regs_r[bank_r][out_c_idx_s];
    assign bus.pair_out  = pair_val_s;
    assign bus.pair_wrap = pair_wrap_r;
    assign bus.bank      = bank_r;

endmodule

// File: tb/tb_reg_file_banked.sv
// -----------------------------------------------------------------------------
// tb_reg_file_banked
//   Directed scenarios followed by random traffic, each step checked against
//   an arithmetic model of the register file kept as plain integer arrays.
// -----------------------------------------------------------------------------
module tb_reg_file_banked;

    localparam int DW = 8;
    localparam int NR = 16;
    localparam int NB = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_file_banked_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_BANKS(NB)) bus ();

    reg_file_banked #(.DATA_W(DW), .NUM_REGS(NR), .NUM_BANKS(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int m [NB][NR];
    int bank_m;
    int wrap_m;
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < NR; r++)
                m[b][r] = 0;
        bank_m = 0;
        wrap_m = 0;
    endtask

    function automatic int pair_val(input int b, input int p);
        return m[b][2*p+1] * 256 + m[b][2*p];
    endfunction

    task automatic check_outs();
        int b;
        b = bank_m;
        chk("out_a",     32'(bus.out_a),     32'(m[b][int'(bus.in_sel)]));
        chk("out_b",     32'(bus.out_b),     32'(m[b][int'(bus.out_b_sel)]));
        chk("out_c",     32'(bus.out_c),     32'(m[b][(int'(bus.out_b_sel) + 1) % NR]));
        chk("pair_out",  32'(bus.pair_out),  32'(pair_val(b, int'(bus.pair_sel))));
        chk("pair_wrap", 32'(bus.pair_wrap), 32'(wrap_m));
        chk("bank",      32'(bus.bank),      32'(bank_m));
    endtask

    task automatic drive(input logic we, input logic i, input logic d, input logic sw,
                         input int isel, input int bsel, input int psel, input int data);
        bus.write_en  = we;
        bus.inc       = i;
        bus.dec       = d;
        bus.bank_swap = sw;
        bus.in_sel    = 4'(isel);
        bus.out_b_sel = 4'(bsel);
        bus.pair_sel  = 3'(psel);
        bus.din       = 8'(data);
    endtask

    // One clock edge: update the model from the applied inputs, then check.
    task automatic step();
        int b, p, v, w;
        @(posedge clk);
        b = bank_m;
        p = int'(bus.pair_sel);
        v = pair_val(b, p);
        w = 0;
        if (bus.write_en) begin
            m[b][int'(bus.in_sel)] = int'(bus.din);
        end else if (bus.inc && !bus.dec) begin
            w = (v == 65535) ? 1 : 0;
            v = (v + 1) % 65536;
            m[b][2*p+1] = v / 256;
            m[b][2*p]   = v % 256;
        end else if (bus.dec && !bus.inc) begin
            w = (v == 0) ? 1 : 0;
            v = (v + 65535) % 65536;
            m[b][2*p+1] = v / 256;
            m[b][2*p]   = v % 256;
        end
        wrap_m = w;
        if (bus.bank_swap) bank_m = (bank_m + 1) % NB;
        #1;
        check_outs();
    endtask

    initial begin
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        rst = 1'b1;
        #12;
        check_outs();
        @(negedge clk);
        rst = 1'b0;

        // Write r3 and r0, read back through out_b and wrapped out_c.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 3, 0, 8'h3C);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3, 3, 0, 8'hA5);
        step();
        chk("t2_out_b_a5", 32'(bus.out_b), 32'h0000_00A5);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 3, 15, 0, 0);
        #1;
        chk("t2_out_c_wrap", 32'(bus.out_c), 32'h0000_003C);
        check_outs();

        // Carry from low to high byte, then a full wrap of pair 7.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2, 2, 1, 8'hFF); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 3, 2, 1, 8'h00); step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 1, 0);     step();
        chk("t3_pair1",   32'(bus.pair_out),  32'h0000_0100);
        chk("t3_r3",      32'(bus.out_c),     32'h0000_0001);
        chk("t3_nowrap",  32'(bus.pair_wrap), 32'h0000_0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 14, 0, 7, 8'hFF); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 15, 0, 7, 8'hFF); step();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 7, 0);      step();
        chk("t3_pair7",   32'(bus.pair_out),  32'h0000_0000);
        chk("t3_wrap",    32'(bus.pair_wrap), 32'h0000_0001);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 7, 0);      step();
        chk("t3_wrap_1cyc", 32'(bus.pair_wrap), 32'h0000_0000);

        // Decrement of zero wraps; inc and dec together do nothing.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 2, 0); step();
        chk("t4_pair2",  32'(bus.pair_out),  32'h0000_FFFF);
        chk("t4_wrap",   32'(bus.pair_wrap), 32'h0000_0001);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 2, 0); step();
        chk("t4_both",   32'(bus.pair_out),  32'h0000_FFFF);
        chk("t4_bothwr", 32'(bus.pair_wrap), 32'h0000_0000);

        // Write wins over inc on the same edge.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 8'h5A); step();
        chk("t5_pair0", 32'(bus.pair_out), 32'h0000_005A);

        // Swap and write on one edge: the write lands in the old bank.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 5, 5, 2, 8'h11); step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 5, 5, 2, 8'h22); step();
        chk("t6_bank1",  32'(bus.bank),  32'h0000_0001);
        chk("t6_b1_r5",  32'(bus.out_b), 32'h0000_0000);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5, 5, 2, 0);     step();
        chk("t6_bank0",  32'(bus.bank),  32'h0000_0000);
        chk("t6_b0_r5",  32'(bus.out_b), 32'h0000_0022);

        // Random traffic; data biased towards 00/FF so pair wraps occur.
        for (int n = 0; n < 400; n++) begin
            int sel;
            int data;
            sel  = $urandom_range(0, 3);
            data = (sel == 0) ? 8'hFF : (sel == 1) ? 8'h00 : int'($urandom_range(0, 255));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                  int'($urandom_range(0, NR / 2 - 1)), data);
            step();
        end

        // Asynchronous reset mid-run clears everything at once.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4, 4, 2, 8'h77);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outs();
        chk("t1_pair_out", 32'(bus.pair_out), 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 3, 0); step();
        chk("t1_after_inc", 32'(bus.pair_out), 32'h0000_0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
